// File: rtl/dyn_segled_pkg.sv
// dyn_segled_pkg: shared constants for the multiplexed 7-segment driver.
//   - register byte offsets (decoded on addr[3:2], addr[1:0] ignored)
//   - hex-to-segment table, active-high, bit order {g,f,e,d,c,b,a}
//   - decoded address width
package dyn_segled_pkg;

    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] OFF_DATA = 4'h0;
    localparam logic [ADDR_W-1:0] OFF_EN   = 4'h4;
    localparam logic [ADDR_W-1:0] OFF_DIV  = 4'h8;
    localparam logic [ADDR_W-1:0] OFF_DP   = 4'hC;

    // Entry i is the active-high segment pattern for hex digit i.
    // These are the bitwise complement of the usual common-anode codes
    // (0 -> C0, 1 -> F9, ...); 'b' and 'd' use the lowercase shapes.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex digit to 7-segment decoder.
//   hex_i  in  4  hex value 0..F
//   seg_o  out 7  active-high segments {g,f,e,d,c,b,a}
// Pin polarity is applied by the instantiating block.
module seg_hex_decode
    import dyn_segled_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/dyn_segled.sv
// dyn_segled: memory-mapped driver for a multiplexed (dynamic) 7-segment
// display of up to 8 digits.
//   clk, rst       clock, asynchronous active-high reset
//   wr/waddr/wdata one-cycle register write
//   rd/raddr/rdata one-cycle register read, rdata valid the cycle after rd
//   seg_pin        segments {dp,g,f,e,d,c,b,a}
//   dig_pin        digit selects, bit i = digit i
// Registers: 0x0 DATA (nibble per digit), 0x4 EN[7:0], 0x8 DIV[15:0],
// 0xC DP[7:0] only when DYN_SEGLED_DP_EN is defined (otherwise reads 0 and
// the decimal point stays dark).
module dyn_segled
    import dyn_segled_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DIV_RESET      = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [31:0]           waddr,
    input  logic [31:0]           wdata,
    input  logic                  rd,
    input  logic [31:0]           raddr,
    output logic [31:0]           rdata,
    output logic [7:0]            seg_pin,
    output logic [NUM_DIGITS-1:0] dig_pin
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // "Everything off" pin levels; XOR with these applies polarity.
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [31:0]           data_q;
    logic [7:0]            en_q;
    logic [15:0]           div_q;
    logic [7:0]            dp_mask;
    logic [15:0]           scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    // ---------------- register decode ----------------
    logic [ADDR_W-1:0] wsel, rsel;
    assign wsel = {waddr[3:2], 2'b00};
    assign rsel = {raddr[3:2], 2'b00};

    logic wr_data, wr_en, wr_div;
    assign wr_data = wr && (wsel == OFF_DATA);
    assign wr_en   = wr && (wsel == OFF_EN);
    assign wr_div  = wr && (wsel == OFF_DIV);

    logic unused_addr;
    assign unused_addr = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            en_q   <= '0;
            div_q  <= 16'(DIV_RESET);
        end else begin
            if (wr_data) data_q <= wdata;
            if (wr_en)   en_q   <= wdata[7:0];
            if (wr_div)  div_q  <= wdata[15:0];
        end
    end

`ifdef DYN_SEGLED_DP_EN
    logic [7:0] dp_q;
    logic       wr_dp;
    assign wr_dp = wr && (wsel == OFF_DP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        dp_q <= '0;
        else if (wr_dp) dp_q <= wdata[7:0];
    end
    assign dp_mask = dp_q;
`else
    assign dp_mask = 8'h00;
`endif

    // Read mux works on the current register values, so a read that
    // coincides with a write to the same register returns the old value.
    always_comb begin
        rdata_d = '0;
        case (rsel)
            OFF_DATA: rdata_d = data_q;
            OFF_EN:   rdata_d = {24'b0, en_q};
            OFF_DIV:  rdata_d = {16'b0, div_q};
            OFF_DP:   rdata_d = {24'b0, dp_mask};
            default:  rdata_d = '0;
        endcase
    end

    // ---------------- scan counter ----------------
    logic [15:0] div_eff;
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        dig_idx_d  = dig_idx_q;
        if (wr_div) begin
            // New divider restarts the current slot; digit stays put.
            scan_cnt_d = '0;
        end else if (scan_cnt_q >= div_eff - 16'd1) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                              : dig_idx_q + IDX_W'(1);
        end
    end

    // ---------------- output stage ----------------
    logic [7:0][3:0] nib;
    logic [2:0]      sel;
    logic [6:0]      seg_raw;
    logic            digit_on;

    assign nib      = data_q;
    assign sel      = 3'(dig_idx_q);
    assign digit_on = en_q[sel];

    seg_hex_decode u_dec (
        .hex_i (nib[sel]),
        .seg_o (seg_raw)
    );

    // Both pin sets come from the same dig_idx_q in one register stage,
    // so exactly one select (or none) is active in any cycle.
    always_comb begin
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (digit_on) begin
            seg_d = {dp_mask[sel], seg_raw} ^ SEG_OFF;
            dig_d = (NUM_DIGITS'(1) << dig_idx_q) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            dig_idx_q  <= '0;
            rdata_q    <= '0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_OFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            if (rd) rdata_q <= rdata_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign rdata   = rdata_q;
    assign seg_pin = seg_q;
    assign dig_pin = dig_q;

endmodule

// File: tb/tb_dyn_segled.sv
module tb_dyn_segled;

    logic        clk = 1'b0;
    logic        rst, wr, rd;
    logic [31:0] waddr, wdata, raddr;
    logic [31:0] rdata;
    logic [7:0]  seg_pin;
    logic [7:0]  dig_pin;

    int checks = 0;
    int errors = 0;

    // Common-anode codes for hex 0..F, dp off (bit 7 high).
    logic [7:0] ca [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    dyn_segled dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .waddr   (waddr),
        .wdata   (wdata),
        .rd      (rd),
        .raddr   (raddr),
        .rdata   (rdata),
        .seg_pin (seg_pin),
        .dig_pin (dig_pin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        waddr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        raddr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset, then DATA, EN, DIV; DIV last so the slot count starts at 0.
    task automatic setup(input logic [31:0] dat, input logic [7:0] en, input logic [15:0] dv);
        do_reset();
        wr_reg(32'h0, dat);
        wr_reg(32'h4, {24'b0, en});
        wr_reg(32'h8, {16'b0, dv});
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
        tick(); tick();
        checks++;
        if ({dig_pin, seg_pin} !== 16'hFFFF) begin
            errors++; $display("FAIL reset_pins: got %h expected FFFF", {dig_pin, seg_pin});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({dig_pin, seg_pin} !== 16'hFFFF) begin
            errors++; $display("FAIL post_reset_pins: got %h expected FFFF", {dig_pin, seg_pin});
        end
        rd_reg(32'h8, r);
        checks++;
        if (r !== 32'd50000) begin
            errors++; $display("FAIL reset_div: got %0d expected 50000", r);
        end
    endtask

    task automatic test_scan();
        logic [7:0] d_exp;
        setup(32'h7654_3210, 8'hFF, 16'd4);
        // Digit 0 visible from the DIV-write edge plus its full 4-cycle slot.
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            checks++;
            if ({dig_pin, seg_pin} !== {8'hFE, ca[0]}) begin
                errors++; $display("FAIL scan_d0 c%0d: got %h expected %h", c, {dig_pin, seg_pin}, {8'hFE, ca[0]});
            end
        end
        for (int d = 1; d < 8; d++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                d_exp = ~(8'd1 << d);
                checks++;
                if ({dig_pin, seg_pin} !== {d_exp, ca[d]}) begin
                    errors++; $display("FAIL scan_d%0d c%0d: got %h expected %h", d, c, {dig_pin, seg_pin}, {d_exp, ca[d]});
                end
            end
        end
        tick();
        checks++;
        if ({dig_pin, seg_pin} !== {8'hFE, ca[0]}) begin
            errors++; $display("FAIL scan_wrap: got %h expected %h", {dig_pin, seg_pin}, {8'hFE, ca[0]});
        end
    endtask

    task automatic test_hex_div1();
        logic [7:0] d_exp;
        setup(32'hFEDC_BA98, 8'hFF, 16'd1);
        for (int c = 0; c < 2; c++) begin
            if (c > 0) tick();
            checks++;
            if ({dig_pin, seg_pin} !== {8'hFE, ca[8]}) begin
                errors++; $display("FAIL hex_d0 c%0d: got %h expected %h", c, {dig_pin, seg_pin}, {8'hFE, ca[8]});
            end
        end
        for (int d = 1; d < 8; d++) begin
            tick();
            d_exp = ~(8'd1 << d);
            checks++;
            if ({dig_pin, seg_pin} !== {d_exp, ca[8 + d]}) begin
                errors++; $display("FAIL hex_d%0d: got %h expected %h", d, {dig_pin, seg_pin}, {d_exp, ca[8 + d]});
            end
        end
    endtask

    task automatic test_enable();
        logic [15:0] exp;
        setup(32'h7654_3210, 8'h05, 16'd2);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            checks++;
            if ({dig_pin, seg_pin} !== {8'hFE, ca[0]}) begin
                errors++; $display("FAIL en_d0 c%0d: got %h expected %h", c, {dig_pin, seg_pin}, {8'hFE, ca[0]});
            end
        end
        for (int d = 1; d < 8; d++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                exp = (d == 2) ? {8'hFB, ca[2]} : 16'hFFFF;
                checks++;
                if ({dig_pin, seg_pin} !== exp) begin
                    errors++; $display("FAIL en_d%0d c%0d: got %h expected %h", d, c, {dig_pin, seg_pin}, exp);
                end
            end
        end
        tick();
        checks++;
        if ({dig_pin, seg_pin} !== {8'hFE, ca[0]}) begin
            errors++; $display("FAIL en_wrap: got %h expected %h", {dig_pin, seg_pin}, {8'hFE, ca[0]});
        end
    endtask

    task automatic test_regs();
        logic [31:0] r;
        logic [31:0] dp_exp;
        do_reset();
        wr_reg(32'h0, 32'h0000_1234);
        // Same-cycle write and read of DATA returns the old value.
        waddr = 32'h0; wdata = 32'h0000_ABCD; wr = 1'b1;
        raddr = 32'h0; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (rdata !== 32'h0000_1234) begin
            errors++; $display("FAIL rw_same_cycle: got %h expected 00001234", rdata);
        end
        rd_reg(32'h0, r);
        checks++;
        if (r !== 32'h0000_ABCD) begin
            errors++; $display("FAIL rw_after: got %h expected 0000abcd", r);
        end
        tick(); tick();
        checks++;
        if (rdata !== 32'h0000_ABCD) begin
            errors++; $display("FAIL rdata_hold: got %h expected 0000abcd", rdata);
        end
        wr_reg(32'h4, 32'hFFFF_FF05);
        rd_reg(32'h7, r);
        checks++;
        if (r !== 32'h0000_0005) begin
            errors++; $display("FAIL en_read: got %h expected 00000005", r);
        end
        wr_reg(32'h8, 32'hDEAD_0004);
        rd_reg(32'h8, r);
        checks++;
        if (r !== 32'h0000_0004) begin
            errors++; $display("FAIL div_read: got %h expected 00000004", r);
        end
`ifdef DYN_SEGLED_DP_EN
        dp_exp = 32'h0000_00A5;
`else
        dp_exp = 32'h0;
`endif
        wr_reg(32'hC, 32'hFFFF_FFA5);
        rd_reg(32'hC, r);
        checks++;
        if (r !== dp_exp) begin
            errors++; $display("FAIL dp_read: got %h expected %h", r, dp_exp);
        end
    endtask

    task automatic test_div_edges();
        logic [31:0] r;
        logic [7:0]  exp_dig [4] = '{8'hFE, 8'hFE, 8'hFD, 8'hFB};
        setup(32'h0, 8'hFF, 16'd0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            checks++;
            if (dig_pin !== exp_dig[c]) begin
                errors++; $display("FAIL div0 c%0d: got %h expected %h", c, dig_pin, exp_dig[c]);
            end
        end
        rd_reg(32'h8, r);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL div0_read: got %h expected 0", r);
        end
        // Rewrite DIV once scan_cnt has reached 3: slot restarts from 0.
        setup(32'h0, 8'hFF, 16'd8);
        tick(); tick(); tick();
        wr_reg(32'h8, 32'd8);
        repeat (8) tick();
        checks++;
        if (dig_pin !== 8'hFE) begin
            errors++; $display("FAIL div_restart_hold: got %h expected fe", dig_pin);
        end
        tick();
        checks++;
        if (dig_pin !== 8'hFD) begin
            errors++; $display("FAIL div_restart_adv: got %h expected fd", dig_pin);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r;
        setup(32'h7654_3210, 8'hFF, 16'd2);
        repeat (11) tick();
        checks++;
        if ({dig_pin, seg_pin} !== {8'hDF, ca[5]}) begin
            errors++; $display("FAIL mid_pre: got %h expected %h", {dig_pin, seg_pin}, {8'hDF, ca[5]});
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({dig_pin, seg_pin} !== 16'hFFFF) begin
            errors++; $display("FAIL mid_async: got %h expected FFFF", {dig_pin, seg_pin});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_reg(32'h0, r);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL mid_data: got %h expected 0", r);
        end
        rd_reg(32'h4, r);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL mid_en: got %h expected 0", r);
        end
        wr_reg(32'h4, 32'hFF);
        checks++;
        if ({dig_pin, seg_pin} !== 16'hFFFF) begin
            errors++; $display("FAIL mid_en_edge: got %h expected FFFF", {dig_pin, seg_pin});
        end
        tick();
        checks++;
        if ({dig_pin, seg_pin} !== {8'hFE, ca[0]}) begin
            errors++; $display("FAIL mid_first_digit: got %h expected %h", {dig_pin, seg_pin}, {8'hFE, ca[0]});
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hex_div1();
        test_enable();
        test_regs();
        test_div_edges();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dyn_segled.md
Name: dyn_segled

Overview:
- Memory-mapped driver for an 8-digit multiplexed (dynamic) 7-segment display on the CPU data bus.
- Sits downstream of the top-level data-bus interconnect, next to the static segment, switch and buzzer peripherals, at base 0x0500_0000.
- The CPU writes hex digits, a digit-enable mask and a scan divider. The block scans the digits continuously and drives the segment and digit-select pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (1..8).
- DIV_RESET, 50000: reset value of the scan divider, in clk cycles per digit.
- SEG_ACTIVE_LOW, 1: 1 means segment pins are active-low.
- DIG_ACTIVE_LOW, 1: 1 means digit-select pins are active-low.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write strobe, one cycle.
- waddr  in  32  write byte address; only [3:0] is decoded.
- wdata  in  32  write data.
- rd  in  1  read strobe, one cycle.
- raddr  in  32  read byte address; only [3:0] is decoded.
- rdata  out  32  read data, registered.
- seg_pin  out  8  segments {dp,g,f,e,d,c,b,a}.
- dig_pin  out  NUM_DIGITS  digit selects; bit i selects digit i.

Behaviour:
- Registers, decoded on addr[3:2]:
  - 0x0 DATA[31:0]: nibble i is the hex value for digit i.
  - 0x4 EN[7:0]: digit enable mask.
  - 0x8 DIV[15:0]: scan divider.
  - 0xC: DP[7:0] (see Optional Feature).
- Bits above the defined width: writes ignored, reads return 0. addr[1:0] is ignored.
- Reset, asynchronous, values:
  - DATA=0, EN=0, DIV=DIV_RESET, DP=0.
  - scan_cnt=0, dig_idx=0, rdata=0.
  - seg_pin = all segments off: 8'hFF if SEG_ACTIVE_LOW, else 8'h00.
  - dig_pin = all digits inactive.
- Write: a register updates on the clk edge where wr=1.
- Read:
  - When rd=1, rdata loads the register value at the next edge, i.e. it is valid the cycle after rd.
  - rdata holds when rd=0.
  - If wr and rd target the same register in the same cycle, rdata returns the pre-write value.
- Scan counter:
  - scan_cnt counts 0..DIVeff-1, where DIVeff = max(DIV,1).
  - At DIVeff-1, scan_cnt wraps to 0 and dig_idx advances; dig_idx wraps NUM_DIGITS-1 -> 0.
  - A DIV write clears scan_cnt to 0 in the same edge; dig_idx is unchanged.
  - DIV=1 advances dig_idx every cycle.
- Output stage, registered every cycle from the current dig_idx, DATA, EN and DP:
  - If EN[dig_idx]=1: dig_pin asserts only bit dig_idx; seg_pin = hex decode of nibble dig_idx plus dp.
  - If EN[dig_idx]=0: dig_pin all inactive and seg_pin all off. The slot still consumes its DIVeff cycles.
  - Pins therefore lag dig_idx by one cycle. A DATA or EN write is visible on the pins 2 cycles after the wr cycle if that digit is currently selected.
- Hex decode: 0-9 and A-F (lowercase b and d shapes), standard common-anode codes. Polarity is applied after decoding.
- At most one digit-select is active in any cycle; there is no ghosting cycle.
- Reset mid-scan returns all state to reset values immediately. Scanning resumes from digit 0 after rst deasserts.

Optional Feature:
- Macro DYN_SEGLED_DP_EN.
- Defined: register 0xC holds DP[7:0]. DP[i] lights the decimal point while digit i is displayed; reads return DP.
- Undefined: 0xC writes are ignored, reads return 0, and the dp segment is always off.

Decomposition:
- Package dyn_segled_pkg holds:
  - register offsets (OFF_DATA=4'h0, OFF_EN=4'h4, OFF_DIV=4'h8, OFF_DP=4'hC);
  - the 16-entry hex-to-segment constant table;
  - the address width constant (4).
- One sub-module, seg_hex_decode: 4-bit in, 7-bit active-high segments out, purely combinational. The top applies polarity.
- The top-level interconnect adds a BASEADDR 0x0500_0000 decode and a read-mux entry.

Test Plan:
- Reset values: rst=1 then released -> seg_pin=8'hFF, dig_pin=8'hFF, rdata=0; a read of 0x8 returns 50000.
- Scan timing: write DIV=4, EN=8'hFF, DATA=32'h7654_3210 -> dig_pin goes 8'hFE, FD, FB, ... each held 4 cycles. seg_pin=8'hC0 for digit 0, 8'hF9 for digit 1, 8'hA4 for digit 2. Wrap after digit 7 back to 8'hFE.
- Enable mask: EN=8'h05, DIV=2 -> only digits 0 and 2 are driven. In the other slots dig_pin=8'hFF and seg_pin=8'hFF; each slot still lasts 2 cycles.
- Same-cycle read/write: wr and rd to 0x0 in one cycle, old DATA=32'h1234, wdata=32'hABCD -> rdata=32'h1234 the next cycle; a following read returns 32'hABCD. Reads of unmapped bits and of 0xC (with the macro undefined) return 0.
- DIV edge cases: DIV=0 behaves as DIV=1 (digit changes every cycle). A DIV write while scan_cnt=3 restarts the count from 0.
- Reset mid-scan: assert rst while dig_idx=5 -> pins go inactive immediately, with no clk edge required. After release, DATA=0 and EN=0, and the first digit driven after EN is rewritten is digit 0.
